// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg - shared types, widths and error encoding for the shared memory
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic MEM_ERR_NONE  = 1'b0;
    localparam logic MEM_ERR_RANGE = 1'b1;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // A single channel still needs a one-bit index
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter - round-robin arbiter with one-hot grant and encoded index
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_CH = 2,
    localparam int CH_W  = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] valid,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_any
);

    logic [CH_W-1:0] r_ptr;
    logic [CH_W:0]   w_cand;
    logic [CH_W-1:0] w_idx;
    logic            w_any;

    // Search from r_ptr upward; candidate never exceeds 2*NUM_CH-2, so one
    // conditional subtract is enough for the wrap.
    always_comb begin
        w_cand = '0;
        w_idx  = '0;
        w_any  = 1'b0;
        for (int off = 0; off < NUM_CH; off++) begin
            w_cand = {1'b0, r_ptr} + (CH_W+1)'(off);
            if (w_cand >= (CH_W+1)'(NUM_CH)) begin
                w_cand = w_cand - (CH_W+1)'(NUM_CH);
            end
            if (!w_any && valid[w_cand[CH_W-1:0]]) begin
                w_any = 1'b1;
                w_idx = w_cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        grant        = '0;
        grant[w_idx] = w_any;
    end

    assign grant_idx = w_idx;
    assign grant_any = w_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            if (w_idx == CH_W'(NUM_CH - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter - single-port memory shared by NUM_CH round-robin channels
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    localparam int BE_W       = be_width(DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    input  logic [NUM_CH*BE_W-1:0]   req_be,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [NUM_CH-1:0] w_grant;
    logic [CH_W-1:0]   w_grant_idx;
    logic              w_accept;

    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [BE_W-1:0]   w_sel_be;
    mem_op_e           w_op;

    logic [ADDR_W-1:0] w_word;
    logic [IDX_W-1:0]  w_idx;
    logic              w_in_range;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_mem_q;
    logic              r_rsp_any;
    logic [CH_W-1:0]   r_rsp_ch;
    logic              r_rd_ok;
    logic              r_err;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req_valid),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_accept)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                w_sel_be    = req_be[i*BE_W +: BE_W];
            end
        end
    end

    assign w_op       = mem_op_e'(w_sel_we);
    assign w_word     = w_sel_addr >> OFF_W;
    assign w_in_range = (w_word < ADDR_W'(DEPTH_WORDS));
    assign w_idx      = w_word[IDX_W-1:0];

    // Array port kept free of reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (w_accept && w_in_range) begin
            if (w_op == OP_WRITE) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (w_sel_be[b]) begin
                        mem[w_idx][b*8 +: 8] <= w_sel_wdata[b*8 +: 8];
                    end
                end
            end else begin
                r_mem_q <= mem[w_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_any <= 1'b0;
            r_rsp_ch  <= '0;
            r_rd_ok   <= 1'b0;
            r_err     <= MEM_ERR_NONE;
        end else begin
            r_rsp_any <= w_accept;
            r_rsp_ch  <= w_grant_idx;
            r_rd_ok   <= w_accept && w_in_range && (w_op == OP_READ);
            r_err     <= (w_accept && !w_in_range) ? MEM_ERR_RANGE : MEM_ERR_NONE;
        end
    end

    // Writes and out-of-range reads report zero data
    assign rsp_valid = NUM_CH'(r_rsp_any) << r_rsp_ch;
    assign rsp_rdata = r_rd_ok ? r_mem_q : '0;
    assign rsp_err   = r_err;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shared single-port memory with a parametrised number of request channels and round-robin arbitration. It is the successor to the fixed pair of separate instruction and data memories. The core's instruction port and data port, plus any future DMA or debug-loader master, are served from one backing array through independent valid/ready request channels. Each channel gets one-cycle-latency read responses, byte-enable writes, and an out-of-range error flag.

## Interface
- NUM_CH, 2: number of request channels (1..8)
- ADDR_W, 32: byte-address width per channel
- DATA_W, 32: data width (multiple of 8); BE_W = DATA_W/8
- DEPTH_WORDS, 1024: backing array depth in DATA_W words (power of two)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_CH  per-channel request valid
- req_ready  out  NUM_CH  per-channel grant (combinational)
- req_we  in  NUM_CH  1 = write, 0 = read
- req_addr  in  NUM_CH*ADDR_W  byte address, channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*DATA_W  write data
- req_be  in  NUM_CH*BE_W  byte enables (writes only)
- rsp_valid  out  NUM_CH  one-cycle response pulse to the granted channel
- rsp_rdata  out  DATA_W  read data, shared bus, qualified by rsp_valid
- rsp_err  out  1  out-of-range flag, qualified by rsp_valid

## Operation
- At most one request is accepted per cycle. A request is accepted when req_valid[i] and req_ready[i] are both high.
- Arbitration: round-robin from pointer rr_ptr.
  - Grant goes to the first channel with valid high, searching from rr_ptr upward with wrap-around.
  - After a grant to channel g, rr_ptr <= (g+1) mod NUM_CH.
  - With no valid request, rr_ptr holds.
  - req_ready is low for every non-granted channel.
- Masters hold req_* stable while valid is high and ready is low. Dropping valid before the grant is legal.
- Word index = req_addr >> log2(BE_W). Low address bits are ignored; no misalignment error is raised.
- Out of range (word index >= DEPTH_WORDS):
  - writes are discarded;
  - reads return 0;
  - rsp_err = 1 with the response.
- Writes update only the bytes whose req_be bit is set. be = 0 is a legal no-op write.
- Every accepted request gets exactly one response.
  - Reads return the array word.
  - Writes are acknowledged with rsp_rdata = 0.
- Response register: the granted channel index and error bit are registered alongside the array read.
- Reset:
  - rr_ptr = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Array contents are not reset.
  - A response pending at reset assertion is dropped.

## Timing
- Request accepted in cycle t -> rsp_valid[ch] high in cycle t+1 only, with rsp_rdata and rsp_err valid in that cycle.
- Throughput: one access per cycle. Back-to-back grants to different channels give back-to-back responses.
- Read-after-write: a write accepted in t is visible to a read accepted in t+1 or later. No same-cycle conflict exists because only one access is accepted per cycle.
- Under continuous contention from all NUM_CH channels, each channel is granted exactly once every NUM_CH cycles.
- NUM_CH = 1: req_ready = req_valid and rr_ptr stays 0.
- rsp_valid is a registered output; req_ready is combinational from req_valid and rr_ptr.

## Structure
- Shared package mem_pkg:
  - BE_W derivation
  - clog2-based channel-index width CH_W
  - error encoding constant MEM_ERR_RANGE
- Sub-module rr_arbiter (NUM_CH): valid vector in, one-hot grant and encoded index out, internal rr_ptr.
- The array uses a per-byte write-enable loop so the tools infer block RAM.
- The core's two ports attach as channel 0 (instruction) and channel 1 (data).

## Test plan
- Reset, then read on ch0 at 0x10 after writing 0xDEADBEEF there via ch1 with be = 4'hF -> ch0 rsp_rdata = 0xDEADBEEF one cycle after its grant, rsp_err = 0.
- Byte enables: write 0x11223344 with be = 4'b0101 over 0xAAAAAAAA at 0x20 -> read returns 0xAA22AA44.
- Contention, NUM_CH = 4, all valid for 8 cycles starting with rr_ptr = 0 -> grant order 0,1,2,3,0,1,2,3; each channel gets exactly 2 rsp_valid pulses.
- Out of range, DEPTH_WORDS = 1024: write 0x55 to 0x1000, then read 0x1000 -> write response rsp_err = 1; read returns 0 with rsp_err = 1; word 0 is unchanged.
- Stall hold: ch1 valid while ch0 is granted -> ch1 ready low for that cycle, ch1 granted the next cycle with the same address, and its response is correct.
- Reset asserted asynchronously in the cycle after a grant -> rsp_valid = 0 immediately, no response delivered after release, rr_ptr = 0 (next grant goes to ch0 when ch0 and ch1 are both valid).
